// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM encodings, line levels and baud timing helpers.
// The timing helpers are also used by the transmitter.
package uart_rx_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] PARITY  = 3'd3;
  localparam logic [2:0] STOP    = 3'd4;
  localparam logic [2:0] RECOVER = 3'd5;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  function automatic int cycFor(input int clkHz, input int baud);
    return clkHz / baud;
  endfunction

  function automatic int halfFor(input int clkHz, input int baud);
    return cycFor(clkHz, baud) / 2;
  endfunction

  function automatic int ctrWidth(input int cyc);
    return (cyc <= 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync
  import uart_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= HIGH;
      q    <= HIGH;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled frame reassembly with parity/framing/overrun reporting.
// Good words are pushed into a downstream write FIFO with a one-cycle strobe.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int    BAUDRATE        = 9600,
  parameter int    CLKFREQUENCY    = 100_000_000,
  parameter int    PACKAGESIZE     = 8,
  parameter string PARITYEXISTENCE = "NO",
  parameter string SHIFT           = "MSBFIRST"
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic [PACKAGESIZE-1:0] fifoData,
  output logic                   fifoWrite,
  input  logic                   fifoFull,
  output logic                   parityError,
  output logic                   frameError,
  output logic                   overrun
);

  localparam int CYC  = cycFor(CLKFREQUENCY, BAUDRATE);
  localparam int HALF = halfFor(CLKFREQUENCY, BAUDRATE);
  localparam int CW   = ctrWidth(CYC);
  localparam int BW   = $clog2(PACKAGESIZE + 1);

  localparam logic [CW-1:0] CYC_LAST  = CW'(CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(PACKAGESIZE - 1);

  localparam bit HAS_PARITY  = (PARITYEXISTENCE != "NO");
  localparam bit EVEN_PARITY = (PARITYEXISTENCE == "EVEN");
  localparam bit MSB_FIRST   = (SHIFT == "MSBFIRST");

  logic                   rxs;
  logic [2:0]             state;
  logic [CW-1:0]          count;
  logic [BW-1:0]          bitCount;
  logic [PACKAGESIZE-1:0] shreg;
  logic [PACKAGESIZE-1:0] shregNext;
  logic                   perr;
  logic                   parityBad;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  always_comb begin
    shregNext = MSB_FIRST ? {shreg[PACKAGESIZE-2:0], rxs} : {rxs, shreg[PACKAGESIZE-1:1]};
    parityBad = EVEN_PARITY ? (^shreg ^ rxs) : ~(^shreg ^ rxs);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      bitCount    <= '0;
      shreg       <= '0;
      perr        <= 1'b0;
      fifoData    <= '0;
      fifoWrite   <= 1'b0;
      parityError <= 1'b0;
      frameError  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      fifoWrite   <= 1'b0;
      parityError <= 1'b0;
      frameError  <= 1'b0;
      overrun     <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (rxs == LOW) begin
            state <= START;
            perr  <= 1'b0;
          end
        end
        START: begin
          if (count == HALF_LAST) begin
            count <= '0;
            if (rxs == LOW) begin
              state    <= DATA;
              bitCount <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        DATA: begin
          if (count == CYC_LAST) begin
            count    <= '0;
            shreg    <= shregNext;
            bitCount <= bitCount + 1'b1;
            if (bitCount == BIT_LAST) state <= HAS_PARITY ? PARITY : STOP;
          end else begin
            count <= count + 1'b1;
          end
        end
        PARITY: begin
          if (count == CYC_LAST) begin
            count <= '0;
            perr  <= parityBad;
            state <= STOP;
          end else begin
            count <= count + 1'b1;
          end
        end
        STOP: begin
          // Framing outranks parity; fifoFull only matters for an otherwise good word.
          if (count == CYC_LAST) begin
            count <= '0;
            if (rxs == LOW) begin
              frameError <= 1'b1;
              state      <= RECOVER;
            end else begin
              state <= IDLE;
              if (perr) begin
                parityError <= 1'b1;
              end else if (fifoFull) begin
                overrun <= 1'b1;
              end else begin
                fifoWrite <= 1'b1;
                fifoData  <= shreg;
              end
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        RECOVER: begin
          // A held-low line (break) stays here so it reports only one frame error.
          if (rxs == HIGH) begin
            count <= '0;
            state <= IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          count <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: three configurations, scoreboarded output events.
module tb_uart_rx;

  localparam int CYC  = 10;
  localparam int HALF = 5;

  localparam int K_WRITE = 0;
  localparam int K_PAR   = 1;
  localparam int K_FRAME = 2;
  localparam int K_OVR   = 3;
  localparam int K_NONE  = -1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifoFull = 1'b0;
  logic [2:0] rxv = 3'b111;

  logic [7:0] fd [3];
  logic       fw [3];
  logic       pe [3];
  logic       fe [3];
  logic       ov [3];

  int cyc = 0;
  int passed = 0;
  int total = 0;

  typedef struct {
    int         inst;
    int         kind;
    logic [7:0] data;
    int         when;
  } evt_t;

  evt_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.BAUDRATE(10_000_000), .CLKFREQUENCY(100_000_000), .PACKAGESIZE(8),
            .PARITYEXISTENCE("NO"), .SHIFT("MSBFIRST")) dut0 (
    .clk(clk), .rst(rst), .rx(rxv[0]), .fifoData(fd[0]), .fifoWrite(fw[0]),
    .fifoFull(fifoFull), .parityError(pe[0]), .frameError(fe[0]), .overrun(ov[0]));

  uart_rx #(.BAUDRATE(10_000_000), .CLKFREQUENCY(100_000_000), .PACKAGESIZE(8),
            .PARITYEXISTENCE("EVEN"), .SHIFT("LSBFIRST")) dut1 (
    .clk(clk), .rst(rst), .rx(rxv[1]), .fifoData(fd[1]), .fifoWrite(fw[1]),
    .fifoFull(fifoFull), .parityError(pe[1]), .frameError(fe[1]), .overrun(ov[1]));

  uart_rx #(.BAUDRATE(10_000_000), .CLKFREQUENCY(100_000_000), .PACKAGESIZE(8),
            .PARITYEXISTENCE("ODD"), .SHIFT("MSBFIRST")) dut2 (
    .clk(clk), .rst(rst), .rx(rxv[2]), .fifoData(fd[2]), .fifoWrite(fw[2]),
    .fifoFull(fifoFull), .parityError(pe[2]), .frameError(fe[2]), .overrun(ov[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkCleared(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_fifoWrite%0d", tag, i), 32'(fw[i]), 0);
      check($sformatf("%s_parityError%0d", tag, i), 32'(pe[i]), 0);
      check($sformatf("%s_frameError%0d", tag, i), 32'(fe[i]), 0);
      check($sformatf("%s_overrun%0d", tag, i), 32'(ov[i]), 0);
      check($sformatf("%s_fifoData%0d", tag, i), 32'(fd[i]), 0);
    end
  endtask

  // Called #1 after a rising edge; first line bit starts immediately.
  task automatic sendFrame(input int inst, input logic [7:0] data, input bit msb,
                           input bit hasPar, input logic parBit, input logic stopBit,
                           input int expKind, input int abortBit);
    logic bits[$];
    int   c0;
    evt_t e;
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(msb ? data[7-k] : data[k]);
    if (hasPar) bits.push_back(parBit);
    bits.push_back(stopBit);
    c0 = cyc;
    if (expKind != K_NONE) begin
      e.inst = inst;
      e.kind = expKind;
      e.data = data;
      e.when = c0 + 3 + HALF + (9 + int'(hasPar)) * CYC;
      sb.push_back(e);
    end
    for (int b = 0; b < bits.size(); b++) begin
      rxv[inst] = bits[b];
      if (b == abortBit) begin
        idle(5);
        rst = 1'b1;
        idle(1);
        checkCleared("abort");
        rst = 1'b0;
        rxv[inst] = 1'b1;
        return;
      end
      idle(CYC);
    end
  endtask

  always @(negedge clk) begin
    int   n;
    int   kind;
    evt_t e;
    for (int i = 0; i < 3; i++) begin
      n = int'(fw[i]) + int'(pe[i]) + int'(fe[i]) + int'(ov[i]);
      if (n != 0) begin
        check($sformatf("onehot_dut%0d", i), n, 1);
        kind = fw[i] ? K_WRITE : pe[i] ? K_PAR : fe[i] ? K_FRAME : K_OVR;
        if (sb.size() == 0) begin
          check($sformatf("unexpected_pulse_dut%0d_kind", i), kind, 99);
        end else begin
          e = sb.pop_front();
          check($sformatf("event_dut%0d", i), i, e.inst);
          check($sformatf("event_kind_dut%0d", i), kind, e.kind);
          check($sformatf("event_cycle_dut%0d", i), cyc, e.when);
          if (kind == K_WRITE) check($sformatf("event_data_dut%0d", i), 32'(fd[i]), 32'(e.data));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle(3);
    checkCleared("reset");
    rst = 1'b0;
    idle(5);

    // MSBFIRST, no parity
    sendFrame(0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, K_WRITE, -1);
    idle(20);
    check("hold_fifoData", 32'(fd[0]), 32'hA5);

    // LSBFIRST, even parity
    sendFrame(1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, K_WRITE, -1);
    idle(10);
    sendFrame(1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, K_PAR, -1);
    idle(10);
    check("parity_keeps_data", 32'(fd[1]), 32'h3C);

    // Odd parity, framing error, break, recovery
    sendFrame(2, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, K_WRITE, -1);
    idle(10);
    sendFrame(2, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, K_FRAME, -1);
    rxv[2] = 1'b0;
    idle(50 * CYC);
    rxv[2] = 1'b1;
    idle(20);
    sendFrame(2, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, K_WRITE, -1);
    idle(10);

    // Start glitch, then back-to-back frames
    rxv[0] = 1'b0;
    idle(3);
    rxv[0] = 1'b1;
    idle(30);
    check("glitch_keeps_data", 32'(fd[0]), 32'hA5);
    sendFrame(0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, K_WRITE, -1);
    sendFrame(0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, K_WRITE, -1);
    idle(10);

    // Overrun while full, then normal write
    fifoFull = 1'b1;
    sendFrame(0, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, K_OVR, -1);
    fifoFull = 1'b0;
    idle(10);
    check("overrun_keeps_data", 32'(fd[0]), 32'hFF);
    sendFrame(0, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, K_WRITE, -1);
    idle(10);

    // Reset in the 4th data bit, then a clean frame
    sendFrame(0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, K_NONE, 4);
    idle(30);
    sendFrame(0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, K_WRITE, -1);
    idle(30);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
